slave_serial_port: RTL and testbench

//  Slave-side bus port that sits directly upstream of the slave BRAM memory.

---
 rtl/slave_serial_port.sv | 88 ++++++++
 tb/tb_slave_serial_port.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/slave_serial_port.sv
// slave_serial_port: bit-serial bus slave that drives single-cycle BRAM write/read strobes
// Ports:
//   clk, rstn                      clock and synchronous active-low reset
//   mvalid, smode, swdata          serial beats from the master (address then write data, LSB first)
//   sready, svalid, srdata         idle flag and serial read-data return path (LSB first)
//   mem_addr, mem_wdata            memory address / write word, held between transactions
//   mem_wen, mem_ren               one-cycle memory strobes
//   mem_rdata, mem_rvalid          memory read word and its valid flag
module slave_serial_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mvalid,
  input  logic                  smode,
  input  logic                  swdata,
  output logic                  sready,
  output logic                  svalid,
  output logic                  srdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MAXW + 1);
  localparam logic [CW-1:0] A_C = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] D_C = CW'(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, MEMRD, RWAIT, RDATA} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic mode;
  logic [ADDR_WIDTH-1:0] addr_sr, addr_nx;
  logic [DATA_WIDTH-1:0] wdata_sr, wdata_nx, rdata_sr;
  logic abeat, dbeat, alast, dlast, rlast;
  assign cnt_inc = cnt + 1'b1;
  // right-shift insertion keeps bit i of the serial stream at position i after the last beat
  assign addr_nx = (addr_sr >> 1) | (ADDR_WIDTH'(swdata) << (ADDR_WIDTH - 1));
  assign wdata_nx = (wdata_sr >> 1) | (DATA_WIDTH'(swdata) << (DATA_WIDTH - 1));
  assign abeat = mvalid && (state == IDLE || state == ADDR);
  assign dbeat = mvalid && state == WDATA;
  assign alast = abeat && cnt_inc == A_C;
  assign dlast = dbeat && cnt_inc == D_C;
  assign rlast = state == RDATA && cnt_inc == D_C;
  assign sready = state == IDLE && rstn;
  assign mem_wen = state == MEMWR;
  assign mem_ren = state == MEMRD;
  assign svalid = state == RDATA;
  assign srdata = svalid ? rdata_sr[0] : 1'b0;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = !abeat ? IDLE : !alast ? ADDR : smode ? WDATA : MEMRD;
      ADDR:    state_n = !alast ? ADDR : mode ? WDATA : MEMRD;
      WDATA:   state_n = dlast ? MEMWR : WDATA;
      MEMWR:   state_n = IDLE;
      MEMRD:   state_n = RWAIT;
      RWAIT:   state_n = mem_rvalid ? RDATA : RWAIT;
      RDATA:   state_n = rlast ? IDLE : RDATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_sr  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && mvalid) mode <= smode;
      if (abeat) addr_sr <= addr_nx;
      if (dbeat) wdata_sr <= wdata_nx;
      if (alast) mem_addr <= addr_nx;
      if (dlast) mem_wdata <= wdata_nx;
      cnt <= (alast || dlast || rlast) ? '0 : (abeat || dbeat || state == RDATA) ? cnt_inc : cnt;
      if (state == RWAIT && mem_rvalid) rdata_sr <= mem_rdata;
      else if (state == RDATA) rdata_sr <= rdata_sr >> 1;
    end
  end
endmodule

// File: tb/tb_slave_serial_port.sv
// tb_slave_serial_port: directed self-checking bench for slave_serial_port with a simple memory model
module tb_slave_serial_port;
  logic clk = 1'b0;
  logic rstn, mvalid, smode, swdata;
  logic sready, svalid, srdata, mem_wen, mem_ren, mem_rvalid;
  logic [11:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  int total = 0;
  int passed = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int rdelay = 0;
  int dly = 0;
  logic pend = 1'b0;
  logic [7:0] mem [4096];
  logic [4095:0] vld;

  slave_serial_port dut (
    .clk(clk), .rstn(rstn), .mvalid(mvalid), .smode(smode), .swdata(swdata),
    .sready(sready), .svalid(svalid), .srdata(srdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // memory: never-written words read as 8'h3C; read data appears rdelay cycles after the ren cycle
  assign mem_rvalid = pend && dly == 0;
  always @(posedge clk) begin
    if (!rstn) vld <= '0;
    else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      vld[mem_addr] <= 1'b1;
    end
    if (mem_wen === 1'b1) wen_cnt <= wen_cnt + 1;
    if (mem_ren === 1'b1) ren_cnt <= ren_cnt + 1;
    if (mem_ren) begin
      mem_rdata <= vld[mem_addr] ? mem[mem_addr] : 8'h3C;
      pend <= 1'b1;
      dly <= rdelay;
    end else if (pend) begin
      if (dly == 0) pend <= 1'b0;
      else dly <= dly - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_beats(input logic [19:0] v, input int n, input bit wr, input bit gaps, input bit tog);
    int base;
    base = wen_cnt + ren_cnt;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        mvalid = 1'b0;
        swdata = 1'($urandom);
        smode = 1'($urandom);
        @(negedge clk);
      end
      if (i == n - 1) chk("no_early_strobe", wen_cnt + ren_cnt, base);
      mvalid = 1'b1;
      swdata = v[i];
      smode = (i == 0 || !tog) ? wr : i[0];
      @(negedge clk);
    end
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input bit gaps, input bit tog);
    send_beats({d, a}, 20, 1'b1, gaps, tog);
    chk("wr_wen", mem_wen, 1);
    chk("wr_addr", mem_addr, a);
    chk("wr_wdata", mem_wdata, d);
    chk("wr_sready_busy", sready, 0);
    @(negedge clk);
    chk("wr_wen_drop", mem_wen, 0);
    chk("wr_sready", sready, 1);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] exp, input int d, input bit tog);
    logic [7:0] word;
    int vc;
    rdelay = d;
    send_beats({8'h00, a}, 12, 1'b0, 1'b0, tog);
    chk("rd_ren", mem_ren, 1);
    chk("rd_addr", mem_addr, a);
    chk("rd_no_wen", mem_wen, 0);
    repeat (1 + d) @(negedge clk);
    chk("rd_svalid_early", svalid, 0);
    word = '0;
    vc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vc += int'(svalid);
      word[i] = srdata;
    end
    chk("rd_svalid_len", vc, 8);
    chk("rd_data", word, exp);
    @(negedge clk);
    chk("rd_svalid_drop", svalid, 0);
    chk("rd_sready", sready, 1);
  endtask

  initial begin
    rstn = 1'b0;
    mvalid = 1'b0;
    smode = 1'b0;
    swdata = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sready", sready, 0);
    chk("rst_strobes", {mem_wen, mem_ren, svalid, srdata}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_sready", sready, 1);
    // write 0xA5 to 0x123, then read it back
    do_write(12'h123, 8'hA5, 1'b0, 1'b0);
    do_read(12'h123, 8'hA5, 0, 1'b0);
    // same write with random gaps between beats
    do_write(12'h123, 8'hA5, 1'b1, 1'b0);
    chk("wen_count_a", wen_cnt, 2);
    // memory holds read data back for 3 cycles
    do_read(12'h123, 8'hA5, 3, 1'b0);
    // corner addresses and data, back-to-back, with smode toggling after the first beat
    do_write(12'h000, 8'hFF, 1'b0, 1'b1);
    do_read(12'h000, 8'hFF, 0, 1'b1);
    do_write(12'hFFF, 8'h00, 1'b0, 1'b1);
    do_read(12'hFFF, 8'h00, 0, 1'b1);
    chk("wen_count_b", wen_cnt, 4);
    chk("ren_count_b", ren_cnt, 4);
    // reset in the middle of the data phase of a write to 0x000
    send_beats({8'h77, 12'h000}, 15, 1'b1, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_sready", sready, 0);
    chk("mid_rst_strobes", {mem_wen, mem_ren, svalid, srdata}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_sready", sready, 1);
    do_read(12'h000, 8'h3C, 0, 1'b0);
    chk("aborted_no_wen", wen_cnt, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
